isr_tracker: RTL
================

ISR_TRACKER -- requirements
Module: isr_tracker

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 clk  input  1  system clock, at least 4x the Z80 clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 m1_n, mreq_n, rd_n, iorq_n  input  1 each  raw Z80 bus strobes, asynchronous to clk.
REQ-005 data  input  8  raw Z80 data bus.
REQ-006 trap_state  input  1  current trap flag from the trap/NMI controller.
REQ-007 virtual_enabled  input  1  virtualization enable.
REQ-008 new_isr  output  1  high when the next M1 fetch starts a new instruction, not a prefix continuation.
REQ-009 last_isr_untrap  output  1  high when the last completed instruction was RETN (ED 45).
REQ-010 trap_icount  output  8  instructions completed since trap entry, saturating.
REQ-011 fetch_done  output  1  one-clock pulse per completed opcode fetch.

Function
REQ-012 m1_n, mreq_n, rd_n and iorq_n SHALL each pass through a 2-flop synchronizer; the synced values are m1s, mreqs, rds and iorqs.
REQ-013 fetch_active SHALL be m1s=0 & mreqs=0 & rds=0; an M1 cycle with iorqs=0 (interrupt acknowledge) SHALL NOT count as a fetch.
REQ-014 While fetch_active, data SHALL be registered into op_latch every clock; the last value held before fetch end is the opcode.
REQ-015 Fetch end SHALL be a synced m1s 0->1 transition that follows at least one fetch_active clock; fetch_done SHALL pulse on the clock after the transition is detected.
REQ-016 The decoder states SHALL be NEW, ED, IDX and IDXCB, and transitions SHALL occur only on fetch end.
REQ-017 In NEW, the opcode selects the next state: ED->ED; DD or FD->IDX; CB->NEW (the second byte is an M1 fetch, so the state stays non-boundary); all other opcodes->NEW with the instruction complete.
REQ-018 CB handling: a state CB SHALL exist in place of the CB->NEW case; in CB, any opcode->NEW with the instruction complete.
REQ-019 In IDX: DD or FD->IDX; CB->IDXCB; ED->ED; any other opcode->NEW with the instruction complete.
REQ-020 In IDXCB, the next M1 fetch ends the instruction, because the displacement and operation bytes are non-M1 reads; any opcode->NEW with the instruction complete.
REQ-021 In ED, any opcode->NEW with the instruction complete; untrap_hit SHALL be set if the opcode is 45h.
REQ-022 new_isr SHALL be 1 exactly when the state is NEW.
REQ-023 last_isr_untrap SHALL update only on instruction complete, to untrap_hit & trap_state & virtual_enabled, and SHALL hold its value through prefix fetches.
REQ-024 trap_icount SHALL clear on every clock where trap_state=0, increment on instruction complete while trap_state=1, and saturate at FFh.
REQ-025 All outputs SHALL be registered, and SHALL be valid no later than 3 clocks after the pin-level m1_n rises.
REQ-026 If m1s rises with no preceding fetch_active clock (glitch or INTACK), there SHALL be no state change and no fetch_done.
REQ-027 ED followed by DD or FD SHALL be treated as complete (ED-prefixed NOP) and SHALL go to NEW.

Reset
REQ-028 On rst=1, asynchronously: state=NEW; new_isr=1; last_isr_untrap=0; trap_icount=00h; fetch_done=0; op_latch=00h; synchronizer flops=1 (idle bus).
REQ-029 A fetch in progress when rst deasserts SHALL be ignored unless fetch_active is observed after reset release.
REQ-030 After rst deasserts, the block SHALL take no action until the synchronizers have seen the bus (2 clocks).

Verification
REQ-031 Fetch 00h from NEW -> one fetch_done pulse; new_isr stays 1; last_isr_untrap=0.
REQ-032 Fetch ED then 45h with trap_state=1 and virtual_enabled=1 -> new_isr=0 after ED, =1 after 45; last_isr_untrap=1 after 45 and stays 1 until the next complete instruction (00h) clears it.
REQ-033 Fetch DD, DD, CB, then M1 fetch 06h -> new_isr=0 for three fetches, 1 after the fourth; trap_icount increments by 1 only (trap_state=1).
REQ-034 An INTACK cycle (m1_n=0, iorq_n=0, no mreq_n) -> no fetch_done; state unchanged.
REQ-035 With trap_state=1, complete 300 instructions -> trap_icount=FFh (saturated); drop trap_state -> 00h on the next clock.
REQ-036 Assert rst during the ED state -> new_isr=1 and last_isr_untrap=0 immediately; a subsequent 45h fetch does not set untrap.

Source files
------------

// File: rtl/isr_tracker.sv
// Z80 instruction-boundary tracker: synchronizes the raw bus strobes, decodes
// prefix sequences from completed M1 fetches, and reports untrap/trap counts.
module isr_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       m1_n,
    input  logic       mreq_n,
    input  logic       rd_n,
    input  logic       iorq_n,
    input  logic [7:0] data,
    input  logic       trap_state,
    input  logic       virtual_enabled,
    output logic       new_isr,
    output logic       last_isr_untrap,
    output logic [7:0] trap_icount,
    output logic       fetch_done
);

    typedef enum logic [2:0] {
        S_NEW,
        S_ED,
        S_IDX,
        S_IDXCB,
        S_CB
    } state_t;

    localparam logic [7:0] OP_CB   = 8'hCB;
    localparam logic [7:0] OP_DD   = 8'hDD;
    localparam logic [7:0] OP_ED   = 8'hED;
    localparam logic [7:0] OP_FD   = 8'hFD;
    localparam logic [7:0] OP_RETN = 8'h45;

    logic [1:0] r_m1_sync;
    logic [1:0] r_mreq_sync;
    logic [1:0] r_rd_sync;
    logic [1:0] r_iorq_sync;
    logic [1:0] r_warm;
    logic       r_m1_prev;
    logic       r_fetch_seen;
    logic [7:0] r_op_latch;
    state_t     r_state;

    logic       w_m1s;
    logic       w_mreqs;
    logic       w_rds;
    logic       w_iorqs;
    logic       w_ready;
    logic       w_fetch_active;
    logic       w_fetch_end;
    state_t     w_next_state;
    logic       w_complete;
    logic       w_untrap_hit;

    // Synchronizers reset to the idle (high) bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m1_sync   <= '1;
            r_mreq_sync <= '1;
            r_rd_sync   <= '1;
            r_iorq_sync <= '1;
        end else begin
            r_m1_sync   <= {r_m1_sync[0], m1_n};
            r_mreq_sync <= {r_mreq_sync[0], mreq_n};
            r_rd_sync   <= {r_rd_sync[0], rd_n};
            r_iorq_sync <= {r_iorq_sync[0], iorq_n};
        end
    end

    assign w_m1s   = r_m1_sync[1];
    assign w_mreqs = r_mreq_sync[1];
    assign w_rds   = r_rd_sync[1];
    assign w_iorqs = r_iorq_sync[1];

    // Hold off until the synchronizers have carried real bus values through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_warm <= '0;
        end else if (r_warm != 2'd2) begin
            r_warm <= r_warm + 2'd1;
        end
    end

    assign w_ready        = (r_warm == 2'd2);
    assign w_fetch_active = w_ready & ~w_m1s & ~w_mreqs & ~w_rds & w_iorqs;
    assign w_fetch_end    = w_ready & ~r_m1_prev & w_m1s & r_fetch_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m1_prev    <= 1'b1;
            r_fetch_seen <= 1'b0;
            r_op_latch   <= '0;
        end else begin
            r_m1_prev <= w_m1s;
            if (w_fetch_end) begin
                r_fetch_seen <= 1'b0;
            end else if (w_fetch_active) begin
                r_fetch_seen <= 1'b1;
            end
            if (w_fetch_active) begin
                r_op_latch <= data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_NEW;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_complete   = 1'b0;
        w_untrap_hit = 1'b0;
        if (w_fetch_end) begin
            case (r_state)
                S_NEW: begin
                    if (r_op_latch == OP_ED) begin
                        w_next_state = S_ED;
                    end else if (r_op_latch == OP_DD || r_op_latch == OP_FD) begin
                        w_next_state = S_IDX;
                    end else if (r_op_latch == OP_CB) begin
                        w_next_state = S_CB;
                    end else begin
                        w_next_state = S_NEW;
                        w_complete   = 1'b1;
                    end
                end
                S_IDX: begin
                    if (r_op_latch == OP_DD || r_op_latch == OP_FD) begin
                        w_next_state = S_IDX;
                    end else if (r_op_latch == OP_CB) begin
                        w_next_state = S_IDXCB;
                    end else if (r_op_latch == OP_ED) begin
                        w_next_state = S_ED;
                    end else begin
                        w_next_state = S_NEW;
                        w_complete   = 1'b1;
                    end
                end
                // ED followed by a DD/FD byte is an ED-prefixed NOP, so any byte completes.
                S_ED: begin
                    w_next_state = S_NEW;
                    w_complete   = 1'b1;
                    w_untrap_hit = (r_op_latch == OP_RETN);
                end
                S_IDXCB, S_CB: begin
                    w_next_state = S_NEW;
                    w_complete   = 1'b1;
                end
                default: begin
                    w_next_state = S_NEW;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_isr         <= 1'b1;
            last_isr_untrap <= 1'b0;
            trap_icount     <= '0;
            fetch_done      <= 1'b0;
        end else begin
            fetch_done <= w_fetch_end;
            new_isr    <= (w_next_state == S_NEW);
            if (w_complete) begin
                last_isr_untrap <= w_untrap_hit & trap_state & virtual_enabled;
            end
            if (!trap_state) begin
                trap_icount <= '0;
            end else if (w_complete && trap_icount != 8'hFF) begin
                trap_icount <= trap_icount + 8'd1;
            end
        end
    end

endmodule
